// File: rtl/ma_result_fifo.sv
// ma_result_fifo: circular FIFO capturing moving-average filter output samples
// and presenting them over a valid/ready stream, with sticky overflow and a
// saturating drop counter for samples lost while full.
// Optional build macro MA_FIFO_PEAK_EN adds running max/min peak tracking of
// accepted samples (clear_peak, peak_max, peak_min, peak_valid).
module ma_result_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic signed [15:0]      sample_in,
  input  logic                    sample_pulse,
  output logic signed [15:0]      m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [LVL_W-1:0]        level,
  output logic                    overflow,
  output logic [7:0]              drop_count,
  input  logic                    clear_ovf
`ifdef MA_FIFO_PEAK_EN
  ,
  input  logic                    clear_peak,
  output logic signed [15:0]      peak_max,
  output logic signed [15:0]      peak_min,
  output logic                    peak_valid
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic signed [15:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               ovf_q;
  logic [7:0]         drop_q;

  logic wr_req_c, full_c, pop_c, wr_acc_c, drop_c;

  // Handshake decode: a full FIFO still accepts a write when it pops that cycle
  always_comb begin
    wr_req_c = enable & sample_pulse;
    full_c   = (level_q == LVL_W'(DEPTH));
    pop_c    = (level_q != '0) & m_ready;
    wr_acc_c = wr_req_c & (~full_c | pop_c);
    drop_c   = wr_req_c & full_c & ~pop_c;
    level_d  = level_q;
    case ({wr_acc_c, pop_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Sample storage, cleared on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (wr_acc_c) begin
      mem_q[wr_ptr_q] <= sample_in;
    end
  end

  // Pointers and occupancy counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_acc_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
    end
  end

  // Overflow accounting; a drop in the same cycle as clear_ovf restarts the count at 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else if (drop_c) begin
      ovf_q <= 1'b1;
      if (clear_ovf)            drop_q <= 8'd1;
      else if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end else if (clear_ovf) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end
  end

`ifdef MA_FIFO_PEAK_EN
  logic signed [15:0] pk_max_q, pk_min_q;
  logic               pk_valid_q;

  // Running extremes of accepted samples; clear with a write reseeds from that sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pk_max_q   <= 16'sh8000;
      pk_min_q   <= 16'sh7FFF;
      pk_valid_q <= 1'b0;
    end else if (wr_acc_c) begin
      pk_valid_q <= 1'b1;
      if (clear_peak) begin
        pk_max_q <= sample_in;
        pk_min_q <= sample_in;
      end else begin
        if (sample_in > pk_max_q) pk_max_q <= sample_in;
        if (sample_in < pk_min_q) pk_min_q <= sample_in;
      end
    end else if (clear_peak) begin
      pk_max_q   <= 16'sh8000;
      pk_min_q   <= 16'sh7FFF;
      pk_valid_q <= 1'b0;
    end
  end

  assign peak_max   = pk_max_q;
  assign peak_min   = pk_min_q;
  assign peak_valid = pk_valid_q;
`endif

  assign m_data     = mem_q[rd_ptr_q];
  assign m_valid    = (level_q != '0);
  assign level      = level_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

endmodule
